dmem_responder: RTL and testbench

Responder end of the single merged data-memory port of the dual-issue core. It accepts the one E-stage memory request produced by the issue-slot arbiter and turns it into an SRAM-like bus transaction, holding the pipeline with `d_stall` while the request is in flight. Load data returns to the M stage sign- or zero-extended per op. Write data is replicated to the addressed lanes.

---
 rtl/dmem_responder_pkg.sv | 65 ++++++
 rtl/dmem_responder_load_ext.sv | 39 +++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Purpose: shared op codes, bus size encoding, FSM states and helpers for the data-memory responder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dmem_responder_pkg;

    // Memory op codes, shared with the issue-slot arbiter and the decoder.
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    // data_size encoding on the SRAM-like bus.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } dmem_state_t;

    // Attributes of one in-flight request; also the source of the bus
    // fields once the first request cycle has passed.
    typedef struct packed {
        logic [5:0]  op;
        logic [1:0]  off;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
`ifdef DMEM_KSEG_MAP_EN
        logic        uncached;
`endif
    } req_t;

    function automatic logic [1:0] op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
            default:              return SIZE_WORD;
        endcase
    endfunction

    // Right-aligned store data replicated across every lane the access
    // could touch, so the bus can pick lanes by address alone.
    function automatic logic [31:0] op_wdata(input logic [5:0] op, input logic [31:0] wd);
        case (op)
            OP_SB:   return {4{wd[7:0]}};
            OP_SH:   return {2{wd[15:0]}};
            OP_SW:   return wd;
            default: return 32'h0;
        endcase
    endfunction

    // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) fold onto physical low memory.
    function automatic logic [31:0] kseg_map(input logic [31:0] a);
        return (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
    endfunction

endpackage

// File: rtl/dmem_responder_load_ext.sv
// Purpose: extract and sign/zero-extend the addressed byte/half/word of a raw read word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: op (memory op code), off (byte offset addr[1:0]), raw (bus read word),
//        ext (extended result, right-aligned).
module load_ext
    import dmem_responder_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[7:0];
        case (off)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        // Halfword loads are aligned, so only addr[1] picks the half.
        half_sel = off[1] ? raw[31:16] : raw[15:0];

        case (op)
            OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ext = {24'h0, byte_sel};
            OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ext = {16'h0, half_sel};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: responder for the merged E-stage data-memory request; drives an SRAM-like bus, returns extended load data to M.
// Latency: 2 cycles minimum (request+addr_ok, then data_ok); each missing addr_ok/data_ok adds one cycle.
// Backpressure: d_stall freezes the pipeline while a request is in flight; one transaction outstanding at a time.
// Ports:
//   clk, resetn                      core clock, async active-low reset
//   E_mem_en/ren/wen/op/addr/wdata   E-stage request (already exception-gated)
//   M_mem_rdata                      registered, extended load result for M
//   d_stall                          pipeline freeze
//   data_req/wr/size/addr/wdata      bus request side
//   data_addr_ok/data_ok/rdata       bus response side
//   data_uncached                    kseg1 flag, only with DMEM_KSEG_MAP_EN
// Build option: DMEM_KSEG_MAP_EN enables fixed MIPS kseg0/kseg1 address folding.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              E_mem_en,
    input  logic              E_mem_ren,
    input  logic              E_mem_wen,
    input  logic [5:0]        E_mem_op,
    input  logic [ADDR_W-1:0] E_mem_addr,
    input  logic [DATA_W-1:0] E_mem_wdata,

    output logic [DATA_W-1:0] M_mem_rdata,
    output logic              d_stall,

    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
`ifdef DMEM_KSEG_MAP_EN
    output logic              data_uncached,
`endif
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    dmem_state_t state;
    req_t        req_q;
    req_t        e_req;
    req_t        bus;
    logic [31:0] rdata_q;
    logic [31:0] ext_rdata;

    // A request with neither ren nor wen is still issued as a read, so
    // only wen shapes the transaction.
    logic unused_ren;
    assign unused_ren = E_mem_ren;

    // Bus fields computed straight from the E inputs for the first
    // request cycle.
    always_comb begin
        e_req.op    = E_mem_op;
        e_req.off   = E_mem_addr[1:0];
        e_req.wr    = E_mem_wen;
        e_req.size  = op_size(E_mem_op);
        e_req.wdata = op_wdata(E_mem_op, E_mem_wdata);
`ifdef DMEM_KSEG_MAP_EN
        e_req.addr     = kseg_map(E_mem_addr);
        e_req.uncached = (E_mem_addr[31:29] == 3'b101);
`else
        e_req.addr  = E_mem_addr;
`endif
    end

    // In IDLE the bus follows E directly; from then on it follows the
    // latched copy, so the fields stay put until addr_ok even if E moves.
    assign bus = (state == ST_IDLE) ? e_req : req_q;

    assign data_req   = ((state == ST_IDLE) && E_mem_en) || (state == ST_ADDR);
    assign data_wr    = bus.wr;
    assign data_size  = bus.size;
    assign data_addr  = bus.addr;
    assign data_wdata = bus.wdata;
`ifdef DMEM_KSEG_MAP_EN
    assign data_uncached = bus.uncached;
`endif

    // The data_ok cycle itself does not stall: the load's M cycle follows
    // immediately with rdata_q already updated.
    assign d_stall = ((state == ST_IDLE) && E_mem_en)
                   || (state == ST_ADDR)
                   || ((state == ST_DATA) && !data_data_ok);

    assign M_mem_rdata = rdata_q;

    load_ext u_load_ext (
        .op  (req_q.op),
        .off (req_q.off),
        .raw (data_rdata),
        .ext (ext_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (E_mem_en) begin
                        req_q <= e_req;
                        state <= data_addr_ok ? ST_DATA : ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (data_addr_ok) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (data_data_ok) begin
                        state <= ST_IDLE;
                        // Stores complete without touching the load result.
                        if (!req_q.wr) begin
                            rdata_q <= ext_rdata;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: self-checking bench for dmem_responder; scoreboard of expected load results.
// Latency: n/a.
// Backpressure: bench throttles addr_ok/data_ok per transaction.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk;
    logic        resetn;
    logic        E_mem_en, E_mem_ren, E_mem_wen;
    logic [5:0]  E_mem_op;
    logic [31:0] E_mem_addr, E_mem_wdata;
    logic [31:0] M_mem_rdata;
    logic        d_stall;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
`ifdef DMEM_KSEG_MAP_EN
    logic        data_uncached;
`endif
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_m = 32'h0;
    bit          m_pending = 0;

    dmem_responder #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .E_mem_en     (E_mem_en),
        .E_mem_ren    (E_mem_ren),
        .E_mem_wen    (E_mem_wen),
        .E_mem_op     (E_mem_op),
        .E_mem_addr   (E_mem_addr),
        .E_mem_wdata  (E_mem_wdata),
        .M_mem_rdata  (M_mem_rdata),
        .d_stall      (d_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
`ifdef DMEM_KSEG_MAP_EN
        .data_uncached(data_uncached),
`endif
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference extension: shift the addressed lane down, then extend.
    function automatic logic [31:0] model_ext(input logic [5:0] op, input logic [1:0] off,
                                              input logic [31:0] raw);
        logic [31:0] sb, sh;
        sb = raw >> {off, 3'b000};
        sh = raw >> {off[1], 4'b0000};
        case (op)
            OP_LB:   return {{24{sb[7]}}, sb[7:0]};
            OP_LBU:  return {24'h0, sb[7:0]};
            OP_LH:   return {{16{sh[15]}}, sh[15:0]};
            OP_LHU:  return {16'h0, sh[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] a);
`ifdef DMEM_KSEG_MAP_EN
        if (a[31:30] == 2'b10) return a & 32'h1FFF_FFFF;
`endif
        return a;
    endfunction

    // Start a cycle: inputs change 1 time unit after the rising edge,
    // defaulting to an idle E stage and silent bus.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        E_mem_en     = 1'b0;
        E_mem_ren    = 1'b0;
        E_mem_wen    = 1'b0;
        E_mem_op     = 6'h0;
        E_mem_addr   = $urandom;
        E_mem_wdata  = $urandom;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = $urandom;
    endtask

    // Sample on the falling edge; a load completed last cycle retires
    // its expected value from the scoreboard here.
    task automatic sample_common();
        @(negedge clk);
        if (m_pending) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard: empty queue on load completion");
            end else begin
                exp_m = exp_q.pop_front();
            end
            m_pending = 0;
        end
        check("m_rdata", M_mem_rdata, exp_m);
    endtask

    task automatic idle(input int n, input logic stray);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            data_addr_ok = stray;
            data_data_ok = stray;
            sample_common();
            check("idle_req", {31'h0, data_req}, 32'h0);
            check("idle_stall", {31'h0, d_stall}, 32'h0);
        end
    endtask

    task automatic txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic wen, input int aw, input int dw, input logic [31:0] rdata);
        logic [31:0] e_addr, e_wd;
        logic [1:0]  e_sz;
        int          nreq, nstall;
        e_addr = model_addr(addr);
        case (op)
            OP_SB:   e_wd = {4{wdata[7:0]}};
            OP_SH:   e_wd = {2{wdata[15:0]}};
            OP_SW:   e_wd = wdata;
            default: e_wd = 32'h0;
        endcase
        case (op)
            OP_LB, OP_LBU, OP_SB: e_sz = 2'd0;
            OP_LH, OP_LHU, OP_SH: e_sz = 2'd1;
            default:              e_sz = 2'd2;
        endcase
        if (!wen) exp_q.push_back(model_ext(op, addr[1:0], rdata));

        next_cycle();
        E_mem_en     = 1'b1;
        E_mem_ren    = !wen;
        E_mem_wen    = wen;
        E_mem_op     = op;
        E_mem_addr   = addr;
        E_mem_wdata  = wdata;
        data_addr_ok = (aw == 0);
        sample_common();
        check("c0_req", {31'h0, data_req}, 32'h1);
        check("c0_wr", {31'h0, data_wr}, {31'h0, wen});
        check("c0_size", {30'h0, data_size}, {30'h0, e_sz});
        check("c0_addr", data_addr, e_addr);
        check("c0_wdata", data_wdata, e_wd);
`ifdef DMEM_KSEG_MAP_EN
        check("c0_uncached", {31'h0, data_uncached}, {31'h0, addr[31:29] == 3'b101});
`endif
        nreq   = data_req;
        nstall = d_stall;

        for (int k = 1; k <= aw; k++) begin
            next_cycle();
            data_addr_ok = (k == aw);
            data_data_ok = $urandom_range(0, 1);
            sample_common();
            check("hold_addr", data_addr, e_addr);
            check("hold_wdata", data_wdata, e_wd);
            check("hold_size", {30'h0, data_size}, {30'h0, e_sz});
`ifdef DMEM_KSEG_MAP_EN
            check("hold_uncached", {31'h0, data_uncached}, {31'h0, addr[31:29] == 3'b101});
`endif
            nreq   += data_req;
            nstall += d_stall;
        end

        for (int j = 0; j <= dw; j++) begin
            next_cycle();
            data_addr_ok = $urandom_range(0, 1);
            data_data_ok = (j == dw);
            if (j == dw) data_rdata = rdata;
            sample_common();
            check("data_req_low", {31'h0, data_req}, 32'h0);
            check("data_stall", {31'h0, d_stall}, {31'h0, j != dw});
            nreq   += data_req;
            nstall += d_stall;
            if (j == dw && !wen) m_pending = 1;
        end
        check("req_cycles", nreq, aw + 1);
        check("stall_cycles", nstall, aw + dw + 1);
    endtask

    initial begin
        resetn       = 1'b0;
        E_mem_en     = 1'b0;
        E_mem_ren    = 1'b0;
        E_mem_wen    = 1'b0;
        E_mem_op     = 6'h0;
        E_mem_addr   = 32'h0;
        E_mem_wdata  = 32'h0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'h0, data_req}, 32'h0);
        check("rst_stall", {31'h0, d_stall}, 32'h0);
        check("rst_rdata", M_mem_rdata, 32'h0);

        next_cycle();
        resetn = 1'b1;
        sample_common();

        // Minimum-latency LB, top byte of the word.
        txn(OP_LB, 32'h1000_0003, 32'h0, 1'b0, 0, 0, 32'h8012_3456);
        idle(2, 1'b1);
        // Half loads, back to back.
        txn(OP_LHU, 32'h1000_0002, 32'h0, 1'b0, 0, 0, 32'h9ABC_1234);
        txn(OP_LH,  32'h1000_0002, 32'h0, 1'b0, 0, 0, 32'h9ABC_1234);
        // Store leaves the previous load result in place.
        txn(OP_SB, 32'h1000_0001, 32'h1234_56A5, 1'b1, 0, 0, 32'hFFFF_FFFF);
        idle(1, 1'b0);
        // Slow bus: three cycles without addr_ok, two without data_ok.
        txn(OP_LW, 32'h2000_0010, 32'h0, 1'b0, 3, 2, 32'hCAFE_F00D);
        txn(OP_SH, 32'h2000_0002, 32'hDEAD_BEEF, 1'b1, 1, 1, 32'h0);
        txn(OP_SW, 32'h2000_0004, 32'h0BAD_F00D, 1'b1, 0, 1, 32'h0);
        txn(OP_LB,  32'h2000_0001, 32'h0, 1'b0, 1, 0, 32'h1122_F344);
        txn(OP_LBU, 32'h2000_0000, 32'h0, 1'b0, 0, 2, 32'h1122_33C4);
        txn(OP_LH,  32'h2000_0000, 32'h0, 1'b0, 2, 0, 32'h8000_7FFE);
        idle(2, 1'b1);

`ifdef DMEM_KSEG_MAP_EN
        txn(OP_LW, 32'hBFAF_F000, 32'h0, 1'b0, 1, 0, 32'h1357_9BDF);
        txn(OP_LW, 32'h8000_0010, 32'h0, 1'b0, 0, 1, 32'h2468_ACE0);
        txn(OP_LW, 32'h4000_0020, 32'h0, 1'b0, 0, 0, 32'h0F0F_0F0F);
        idle(1, 1'b0);
`endif

        // Reset while waiting in DATA, then a stray data_ok.
        next_cycle();
        E_mem_en     = 1'b1;
        E_mem_ren    = 1'b1;
        E_mem_op     = OP_LW;
        E_mem_addr   = 32'h3000_0000;
        data_addr_ok = 1'b1;
        sample_common();
        next_cycle();
        sample_common();
        check("pre_rst_stall", {31'h0, d_stall}, 32'h1);
        next_cycle();
        resetn = 1'b0;
        exp_q.delete();
        exp_m     = 32'h0;
        m_pending = 0;
        sample_common();
        check("rst_mid_stall", {31'h0, d_stall}, 32'h0);
        check("rst_mid_req", {31'h0, data_req}, 32'h0);
        next_cycle();
        resetn       = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h8765_4321;
        sample_common();
        check("stray_stall", {31'h0, d_stall}, 32'h0);
        check("stray_req", {31'h0, data_req}, 32'h0);
        idle(2, 1'b0);

        // Normal operation resumes after the interrupted transaction.
        txn(OP_LBU, 32'h3000_0003, 32'h0, 1'b0, 0, 0, 32'hA5FF_FFFF);
        idle(1, 1'b0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
